interrupt_exception_sequencer: RTL and testbench
================================================

# interrupt_exception_sequencer

Consumes the interrupt request and 8-bit vector number produced by the priority determination stage. Runs the CPU-side exception entry sequence: it waits for an instruction boundary, pushes PC/CCR (and EXR in interrupt control mode 2) to the stack, and fetches the vector-table entry. It then hands the new PC, SP and mask updates to the CPU and pulses an acknowledge back to the interrupt controller so the accepted source can be cleared.

## Interface
Parameters:
- ADDR_W, 24, bus address width; also the PC width.
- DATA_W, 32, bus data width; stack pushes are one longword each.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- interrupt_request  in  1  pending interrupt from priority determination.
- vector_number  in  8  vector of the pending request; 8'h07 = NMI.
- req_level  in  3  priority level of the pending request; ignored for NMI.
- INTM0, INTM1  in  1  interrupt control mode. Mode 2 = INTM1=1, INTM0=0.
- insn_boundary  in  1  CPU is between instructions; an exception may start.
- cpu_pc  in  ADDR_W  return PC.
- cpu_ccr  in  8  current CCR.
- cpu_exr  in  8  current EXR; bits [2:0] are the mask.
- cpu_sp  in  32  current ER7.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  transaction complete this cycle.
- bus_rdata  in  DATA_W  read data, valid when bus_ack=1.
- busy  out  1  sequence in progress; CPU holds instruction fetch.
- pc_load  out  1  one-cycle pulse; CPU loads new_pc.
- new_pc  out  ADDR_W  vector-table target.
- sp_load  out  1  one-cycle pulse, coincident with pc_load.
- new_sp  out  32  updated stack pointer.
- ccr_i_set  out  1  one-cycle pulse, coincident with pc_load; set CCR.I.
- exr_load  out  1  one-cycle pulse with pc_load, mode 2 only.
- new_exr  out  8  {cpu_exr[7] cleared (T=0), cpu_exr[6:3], new mask}.
- int_ack  out  1  one-cycle pulse, coincident with pc_load.
- ack_vector  out  8  latched vector, valid while int_ack=1.

## Operation
- States: IDLE, PUSH_PC, PUSH_EXR, FETCH, DONE.
- IDLE:
  - Waits for interrupt_request=1 and insn_boundary=1 in the same cycle.
  - On that edge it latches vector, level, cpu_pc, cpu_ccr, cpu_exr, cpu_sp and mode2 = INTM1 & ~INTM0.
  - NMI (vector 8'h07) forces the latched level to 3'd7.
  - Next state is PUSH_PC.
- PUSH_PC:
  - Write at sp_l-4, data {ccr_l, pc_l}.
  - On bus_ack, go to PUSH_EXR if mode2, else FETCH.
- PUSH_EXR:
  - Write at sp_l-8, data {24'h0, exr_l}.
  - On bus_ack, go to FETCH.
- FETCH:
  - Read at {14'h0, vector_l, 2'b00}.
  - On bus_ack, capture bus_rdata[ADDR_W-1:0] into new_pc and go to DONE.
- DONE:
  - Pulse pc_load, sp_load, ccr_i_set and int_ack; pulse exr_load if mode2.
  - new_sp = sp_l-4, or sp_l-8 in mode2; 32-bit arithmetic, wraps modulo 2^32.
  - Bus addresses use the low ADDR_W bits of the subtraction result.
  - new_exr[2:0] = latched level.
  - Next state is IDLE.
- interrupt_request, vector_number and the mode inputs are ignored outside IDLE. Changes mid-sequence do not affect the latched vector.
- INTM0=1 with INTM1=0 still runs the sequence, with mode2=0.

## Timing
- Every state that issues a transaction holds bus_req, bus_we, bus_addr and bus_wdata stable until the edge where bus_ack=1 is sampled.
- bus_ack may be high in the first req cycle (zero wait).
- bus_req drops in the cycle after ack; transactions are never back-to-back in the same cycle.
- bus_ack outside PUSH_PC/PUSH_EXR/FETCH is ignored.
- Minimum latency, zero-wait bus, from the accept edge E:
  - Mode 0: PUSH_PC in cycle E+1, FETCH in E+2, DONE (pulses) in E+3, IDLE in E+4.
  - Mode 2: one extra cycle; pulses in E+4.
- Each wait cycle on bus_ack adds exactly one cycle.
- busy=1 from E+1 through DONE inclusive.
- A new request may be accepted on the edge that ends DONE's following IDLE cycle. Earliest re-accept is E+4 in mode 0.
- Reset values: state IDLE; all outputs 0, including new_pc, new_sp, new_exr, bus_addr, bus_wdata and ack_vector.
- rst high mid-sequence: at that edge return to IDLE and clear all outputs. bus_req goes low the following cycle. No pc_load or int_ack is issued for the aborted sequence.

## Test plan
- Mode 0, zero-wait:
  - Stimulus: vector 8'h40, sp 32'h0000_FF00, pc 24'h001234, ccr 8'h00.
  - Response: write ff_fc/32'h00001234, then read 24'h000100; rdata 32'h00ABCDEF gives new_pc 24'hABCDEF.
  - Response: new_sp 32'h0000FEFC; pulses at E+3.
- Mode 2, level 5, exr 8'h82:
  - Response: writes at FEFC and FEF8 (data 32'h82).
  - Response: new_exr 8'h05, new_sp 32'h0000FEF8, exr_load pulse at E+4.
- NMI in mode 2:
  - Stimulus: vector 8'h07, req_level 3'd2.
  - Response: fetch address 24'h00001C, new_exr[2:0]=3'd7.
- Wait states:
  - Stimulus: bus_ack delayed 3 cycles on every transaction, mode 0.
  - Response: pulses at E+9; address and data stable throughout each wait.
- Reset mid-sequence:
  - Stimulus: rst during the FETCH wait.
  - Response: state returns to IDLE, no int_ack, all outputs 0.
  - Response: the next request then completes normally.
- Boundary and wrap:
  - Stimulus: interrupt_request held with insn_boundary=0.
  - Response: no bus_req until insn_boundary=1.
  - Stimulus: sp 32'h00000002 in mode 0.
  - Response: push address 24'hFFFFFE, new_sp 32'hFFFFFFFE.

Source files
------------

// File: rtl/interrupt_exception_sequencer.sv
// CPU-side exception entry: waits for an instruction boundary, stacks PC/CCR (and EXR in
// mode 2), fetches the vector, then pulses the PC/SP/mask loads and the interrupt acknowledge.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for interrupt_request together with insn_boundary
//   PUSH_PC   | longword write {ccr, pc} at sp-4
//   PUSH_EXR  | longword write {24'h0, exr} at sp-8 (mode 2 only)
//   FETCH     | vector-table read at vector*4
//   DONE      | one-cycle load/acknowledge pulses, then back to IDLE
module interrupt_exception_sequencer #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt_request,
  input  logic [7:0]        vector_number,
  input  logic [2:0]        req_level,
  input  logic              INTM0,
  input  logic              INTM1,
  input  logic              insn_boundary,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [7:0]        cpu_ccr,
  input  logic [7:0]        cpu_exr,
  input  logic [31:0]       cpu_sp,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              pc_load,
  output logic [ADDR_W-1:0] new_pc,
  output logic              sp_load,
  output logic [31:0]       new_sp,
  output logic              ccr_i_set,
  output logic              exr_load,
  output logic [7:0]        new_exr,
  output logic              int_ack,
  output logic [7:0]        ack_vector
);

  localparam logic [7:0] NMI_VECTOR = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_EXR,
    S_FETCH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        vector_q, vector_d;
  logic [2:0]        level_q, level_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ccr_q, ccr_d;
  logic [7:0]        exr_q, exr_d;
  logic [31:0]       sp_q, sp_d;
  logic              mode2_q, mode2_d;

  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [31:0]       new_sp_q, new_sp_d;
  logic [7:0]        new_exr_q, new_exr_d;
  logic [7:0]        ack_vector_q, ack_vector_d;

  logic [31:0] sp_m4;
  logic [31:0] sp_m8;
  logic        unused_rdata_hi;

  // Stack arithmetic wraps modulo 2^32; the bus only sees the low ADDR_W bits.
  assign sp_m4 = sp_q - 32'd4;
  assign sp_m8 = sp_q - 32'd8;

  // Only the low ADDR_W bits of a vector-table entry form the PC.
  assign unused_rdata_hi = ^bus_rdata[DATA_W-1:ADDR_W];

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    level_d      = level_q;
    pc_d         = pc_q;
    ccr_d        = ccr_q;
    exr_d        = exr_q;
    sp_d         = sp_q;
    mode2_d      = mode2_q;
    new_pc_d     = new_pc_q;
    new_sp_d     = new_sp_q;
    new_exr_d    = new_exr_q;
    ack_vector_d = ack_vector_q;

    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    pc_load   = 1'b0;
    sp_load   = 1'b0;
    ccr_i_set = 1'b0;
    exr_load  = 1'b0;
    int_ack   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (interrupt_request && insn_boundary) begin
          vector_d = vector_number;
          level_d  = (vector_number == NMI_VECTOR) ? 3'd7 : req_level;
          pc_d     = cpu_pc;
          ccr_d    = cpu_ccr;
          exr_d    = cpu_exr;
          sp_d     = cpu_sp;
          mode2_d  = INTM1 & ~INTM0;
          state_d  = S_PUSH_PC;
        end
      end

      S_PUSH_PC: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = sp_m4[ADDR_W-1:0];
        bus_wdata = DATA_W'({ccr_q, pc_q});
        if (bus_ack) begin
          state_d = mode2_q ? S_PUSH_EXR : S_FETCH;
        end
      end

      S_PUSH_EXR: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = sp_m8[ADDR_W-1:0];
        bus_wdata = DATA_W'(exr_q);
        if (bus_ack) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = ADDR_W'({vector_q, 2'b00});
        // All results are registered here so they are already stable during DONE.
        if (bus_ack) begin
          new_pc_d     = bus_rdata[ADDR_W-1:0];
          new_sp_d     = mode2_q ? sp_m8 : sp_m4;
          new_exr_d    = {1'b0, exr_q[6:3], level_q};
          ack_vector_d = vector_q;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        pc_load   = 1'b1;
        sp_load   = 1'b1;
        ccr_i_set = 1'b1;
        exr_load  = mode2_q;
        int_ack   = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vector_q     <= '0;
      level_q      <= '0;
      pc_q         <= '0;
      ccr_q        <= '0;
      exr_q        <= '0;
      sp_q         <= '0;
      mode2_q      <= 1'b0;
      new_pc_q     <= '0;
      new_sp_q     <= '0;
      new_exr_q    <= '0;
      ack_vector_q <= '0;
    end else begin
      state_q      <= state_d;
      vector_q     <= vector_d;
      level_q      <= level_d;
      pc_q         <= pc_d;
      ccr_q        <= ccr_d;
      exr_q        <= exr_d;
      sp_q         <= sp_d;
      mode2_q      <= mode2_d;
      new_pc_q     <= new_pc_d;
      new_sp_q     <= new_sp_d;
      new_exr_q    <= new_exr_d;
      ack_vector_q <= ack_vector_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign new_pc     = new_pc_q;
  assign new_sp     = new_sp_q;
  assign new_exr    = new_exr_q;
  assign ack_vector = ack_vector_q;

endmodule

// File: tb/tb_interrupt_exception_sequencer.sv
// Directed bench for interrupt_exception_sequencer: hand-computed bus traffic, pulse timing,
// wait states, mid-sequence reset, boundary gating and stack-pointer wrap.
module tb_interrupt_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt_request;
  logic [7:0]  vector_number;
  logic [2:0]  req_level;
  logic        INTM0, INTM1;
  logic        insn_boundary;
  logic [23:0] cpu_pc;
  logic [7:0]  cpu_ccr;
  logic [7:0]  cpu_exr;
  logic [31:0] cpu_sp;
  logic        bus_req, bus_we;
  logic [23:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        busy, pc_load, sp_load, ccr_i_set, exr_load, int_ack;
  logic [23:0] new_pc;
  logic [31:0] new_sp;
  logic [7:0]  new_exr, ack_vector;

  int checks   = 0;
  int failures = 0;

  interrupt_exception_sequencer #(.ADDR_W(24), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .interrupt_request(interrupt_request), .vector_number(vector_number),
    .req_level(req_level), .INTM0(INTM0), .INTM1(INTM1),
    .insn_boundary(insn_boundary), .cpu_pc(cpu_pc), .cpu_ccr(cpu_ccr),
    .cpu_exr(cpu_exr), .cpu_sp(cpu_sp),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .pc_load(pc_load), .new_pc(new_pc), .sp_load(sp_load), .new_sp(new_sp),
    .ccr_i_set(ccr_i_set), .exr_load(exr_load), .new_exr(new_exr),
    .int_ack(int_ack), .ack_vector(ack_vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request on an IDLE cycle, take the accept edge, then scramble the
  // inputs so any failure to latch shows up later.
  task automatic accept(input logic [7:0] vec, input logic [2:0] lvl, input logic m1,
                        input logic m0, input logic [23:0] pc, input logic [7:0] ccr,
                        input logic [7:0] exr, input logic [31:0] sp);
    vector_number = vec; req_level = lvl; INTM1 = m1; INTM0 = m0;
    cpu_pc = pc; cpu_ccr = ccr; cpu_exr = exr; cpu_sp = sp;
    interrupt_request = 1'b1; insn_boundary = 1'b1;
    tick();
    interrupt_request = 1'b0; insn_boundary = 1'b0;
    vector_number = 8'hEE; req_level = 3'd1; INTM1 = 1'b0; INTM0 = 1'b0;
    cpu_pc = 24'h5A5A5A; cpu_ccr = 8'h5A; cpu_exr = 8'h5A; cpu_sp = 32'hDEAD_BEEF;
  endtask

  task automatic check_bus(input string tag, input logic we, input logic [23:0] addr,
                           input logic [31:0] wdata);
    check({tag, "_req"}, 32'(bus_req), 32'd1);
    check({tag, "_we"}, 32'(bus_we), 32'(we));
    check({tag, "_addr"}, 32'(bus_addr), 32'(addr));
    if (we) check({tag, "_wdata"}, bus_wdata, wdata);
  endtask

  task automatic check_done(input string tag, input logic [23:0] pc, input logic [31:0] sp,
                            input logic [7:0] exr, input logic [7:0] vec, input logic m2);
    check({tag, "_pc_load"}, 32'(pc_load), 32'd1);
    check({tag, "_sp_load"}, 32'(sp_load), 32'd1);
    check({tag, "_ccr_i_set"}, 32'(ccr_i_set), 32'd1);
    check({tag, "_int_ack"}, 32'(int_ack), 32'd1);
    check({tag, "_exr_load"}, 32'(exr_load), 32'(m2));
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_new_pc"}, 32'(new_pc), 32'(pc));
    check({tag, "_new_sp"}, new_sp, sp);
    check({tag, "_ack_vector"}, 32'(ack_vector), 32'(vec));
    if (m2) check({tag, "_new_exr"}, 32'(new_exr), 32'(exr));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    check({tag, "_int_ack"}, 32'(int_ack), 32'd0);
  endtask

  initial begin
    rst = 1'b1; interrupt_request = 1'b0; vector_number = 8'h00; req_level = 3'd0;
    INTM0 = 1'b0; INTM1 = 1'b0; insn_boundary = 1'b0; cpu_pc = '0; cpu_ccr = '0;
    cpu_exr = '0; cpu_sp = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_idle("rst");
    check("rst_new_pc", 32'(new_pc), 32'd0);
    check("rst_new_sp", new_sp, 32'd0);
    check("rst_new_exr", 32'(new_exr), 32'd0);
    check("rst_ack_vector", 32'(ack_vector), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_sp_load", 32'(sp_load), 32'd0);
    check("rst_exr_load", 32'(exr_load), 32'd0);
    tick();

    // Mode 0, zero wait: push at E+1, fetch at E+2, pulses at E+3, IDLE at E+4
    accept(8'h40, 3'd3, 1'b0, 1'b0, 24'h001234, 8'h00, 8'h00, 32'h0000_FF00);
    check("m0_busy", 32'(busy), 32'd1);
    check_bus("m0_push", 1'b1, 24'h00FEFC, 32'h0000_1234);
    bus_ack = 1'b1;
    tick();
    check_bus("m0_fetch", 1'b0, 24'h000100, 32'h0);
    check("m0_fetch_no_pulse", 32'(pc_load), 32'd0);
    bus_rdata = 32'h00AB_CDEF;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check_done("m0", 24'hABCDEF, 32'h0000_FEFC, 8'h00, 8'h40, 1'b0);
    tick();
    check_idle("m0_after");

    // Mode 2, level 5, exr 0x82; accepted back-to-back at E+4 of the previous sequence
    accept(8'h50, 3'd5, 1'b1, 1'b0, 24'h005678, 8'h85, 8'h82, 32'h0000_FF00);
    check_bus("m2_push_pc", 1'b1, 24'h00FEFC, 32'h8500_5678);
    bus_ack = 1'b1;
    tick();
    check_bus("m2_push_exr", 1'b1, 24'h00FEF8, 32'h0000_0082);
    tick();
    check_bus("m2_fetch", 1'b0, 24'h000140, 32'h0);
    check("m2_fetch_no_pulse", 32'(pc_load), 32'd0);
    bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check_done("m2", 24'h223344, 32'h0000_FEF8, 8'h05, 8'h50, 1'b1);
    tick();
    check_idle("m2_after");

    // NMI in mode 2: requested level ignored, mask forced to 7, T bit cleared
    accept(8'h07, 3'd2, 1'b1, 1'b0, 24'h000010, 8'h01, 8'hF8, 32'h0010_0000);
    check_bus("nmi_push_pc", 1'b1, 24'h0FFFFC, 32'h0100_0010);
    bus_ack = 1'b1;
    tick();
    check_bus("nmi_push_exr", 1'b1, 24'h0FFFF8, 32'h0000_00F8);
    tick();
    check_bus("nmi_fetch", 1'b0, 24'h00001C, 32'h0);
    bus_rdata = 32'h0000_0ABC;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check_done("nmi", 24'h000ABC, 32'h000F_FFF8, 8'h7F, 8'h07, 1'b1);
    tick();
    check_idle("nmi_after");

    // Mode 0 with three wait cycles per transaction: pulses at E+9
    accept(8'h21, 3'd4, 1'b0, 1'b1, 24'hABCDEF, 8'h04, 8'h00, 32'h0001_0000);
    for (int i = 0; i < 3; i++) begin
      check_bus("ws_push_wait", 1'b1, 24'h00FFFC, 32'h04AB_CDEF);
      interrupt_request = 1'b1; vector_number = 8'h33;
      tick();
    end
    check_bus("ws_push_ack", 1'b1, 24'h00FFFC, 32'h04AB_CDEF);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bus("ws_fetch_wait", 1'b0, 24'h000084, 32'h0);
      check("ws_fetch_no_pulse", 32'(pc_load), 32'd0);
      tick();
    end
    check_bus("ws_fetch_ack", 1'b0, 24'h000084, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hFF01_2345;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; interrupt_request = 1'b0;
    check_done("ws", 24'h012345, 32'h0000_FFFC, 8'h00, 8'h21, 1'b0);
    tick();
    check_idle("ws_after");

    // Reset during the FETCH wait: no acknowledge, everything cleared
    accept(8'h60, 3'd6, 1'b0, 1'b0, 24'h000200, 8'h00, 8'h00, 32'h0000_8000);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check_bus("rm_fetch", 1'b0, 24'h000180, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rm");
    check("rm_new_pc", 32'(new_pc), 32'd0);
    check("rm_new_sp", new_sp, 32'd0);
    check("rm_new_exr", 32'(new_exr), 32'd0);
    check("rm_ack_vector", 32'(ack_vector), 32'd0);
    check("rm_bus_addr", 32'(bus_addr), 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check_idle("rm_late");

    // Request held without an instruction boundary, then SP wrap in mode 0
    vector_number = 8'h12; req_level = 3'd1; INTM1 = 1'b0; INTM0 = 1'b0;
    cpu_pc = 24'h00ABCD; cpu_ccr = 8'h10; cpu_exr = 8'h00; cpu_sp = 32'h0000_0002;
    interrupt_request = 1'b1; insn_boundary = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("bd_hold");
    end
    insn_boundary = 1'b1;
    tick();
    interrupt_request = 1'b0; insn_boundary = 1'b0;
    check_bus("wr_push", 1'b1, 24'hFFFFFE, 32'h1000_ABCD);
    bus_ack = 1'b1;
    tick();
    check_bus("wr_fetch", 1'b0, 24'h000048, 32'h0);
    bus_rdata = 32'h0000_4444;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check_done("wr", 24'h004444, 32'hFFFF_FFFE, 8'h00, 8'h12, 1'b0);
    tick();
    check_idle("wr_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
